// File: rtl/vga_pkg.sv
// Shared types and colour constants for the VGA output stage.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_GRID   = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_STREAM = 2'd2,
        MODE_SOLID  = 2'd3
    } mode_t;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_RUN      = 1'b1
    } sstate_t;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_LUT = {
        BLACK, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, WHITE
    };

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the VGA output stage plus combinational decode of
// sync pulses, active area, active-pixel coordinates and the frame origin.
module vga_timing #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 12,
    parameter int VPULSE = 3,
    parameter int VBP    = 40
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_hs_act,
    output logic                     o_vs_act,
    output logic                     o_active,
    output logic [$clog2(HDISP)-1:0] o_cx,
    output logic [$clog2(VDISP)-1:0] o_cy,
    output logic                     o_sof_pos
);
    localparam int HSUP   = HFP + HPULSE + HBP;
    localparam int VSUP   = VFP + VPULSE + VBP;
    localparam int HTOTAL = HSUP + HDISP;
    localparam int VTOTAL = VSUP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h == HW'(HTOTAL - 1));
    assign w_v_last = (r_v == VW'(VTOTAL - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    // Blanking sits in front of the active area, so coordinates are plain offsets.
    assign o_hs_act  = (r_h >= HW'(HFP)) && (r_h < HW'(HFP + HPULSE));
    assign o_vs_act  = (r_v >= VW'(VFP)) && (r_v < VW'(VFP + VPULSE));
    assign o_active  = (r_h >= HW'(HSUP)) && (r_v >= VW'(VSUP));
    assign o_cx      = XW'(r_h - HW'(HSUP));
    assign o_cy      = YW'(r_v - VW'(VSUP));
    assign o_sof_pos = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/vga_stream_out.sv
// VGA output stage: self-generated timing, pixel source selection (grid, bars,
// solid, or a valid/ready stream with SOF realignment) and registered outputs.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int          HFP       = 40,
    parameter int          HPULSE    = 48,
    parameter int          HBP       = 40,
    parameter int          VFP       = 12,
    parameter int          VPULSE    = 3,
    parameter int          VBP       = 40,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int          GRID      = 16,
    parameter logic [23:0] UFLOW_RGB = 24'hFF0000
) (
    input  logic                     pixel_clk,
    input  logic                     pixel_rst,
    input  logic [1:0]               mode,
    input  logic [23:0]              solid_rgb,
    input  logic [23:0]              pix_data,
    input  logic                     pix_sof,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic                     hs,
    output logic                     vs,
    output logic                     blank,
    output logic [23:0]              rgb,
    output logic [$clog2(HDISP)-1:0] x,
    output logic [$clog2(VDISP)-1:0] y,
    output logic                     frame_start,
    output logic                     underflow,
    input  logic                     underflow_clr
);
    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);

    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_active;
    logic [XW-1:0] w_cx;
    logic [YW-1:0] w_cy;
    logic          w_sof_pos;
    logic          w_origin;
    logic          w_grid_line;
    logic          w_ready;
    logic          w_uf_set;
    logic [23:0]   w_stream_rgb;
    logic [23:0]   w_pix;
    sstate_t       w_state_nxt;

    mode_t         r_mode_q;
    sstate_t       r_state;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank;
    logic [23:0]   r_rgb;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_frame_start;
    logic          r_underflow;

    vga_timing #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP)
    ) u_timing (
        .i_clk     (pixel_clk),
        .i_rst     (pixel_rst),
        .o_hs_act  (w_hs_act),
        .o_vs_act  (w_vs_act),
        .o_active  (w_active),
        .o_cx      (w_cx),
        .o_cy      (w_cy),
        .o_sof_pos (w_sof_pos)
    );

    // Bar k starts where cx*8 >= k*HDISP; the thresholds are constants so no divider is built.
    function automatic logic [2:0] bar_index(input logic [XW-1:0] cx);
        logic [XW+2:0] cx8;
        logic [2:0]    idx;
        cx8 = {cx, 3'b000};
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (cx8 >= (XW+3)'(k * HDISP)) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

    assign w_origin    = (w_cx == '0) && (w_cy == '0);
    assign w_grid_line = ((w_cx & XW'(GRID - 1)) == '0) || ((w_cy & YW'(GRID - 1)) == '0);

    always_comb begin
        w_ready      = 1'b0;
        w_stream_rgb = BLACK;
        w_uf_set     = 1'b0;
        w_state_nxt  = r_state;
        if (r_mode_q != MODE_STREAM) begin
            w_state_nxt = ST_WAIT_SOF;
        end else if (r_state == ST_WAIT_SOF) begin
            // Drain stale words; an SOF word waits here until the frame origin comes round.
            if (pix_valid && !pix_sof) begin
                w_ready = 1'b1;
            end else if (pix_valid && pix_sof && w_active && w_origin) begin
                w_ready      = 1'b1;
                w_stream_rgb = pix_data;
                w_state_nxt  = ST_RUN;
            end
        end else if (w_active) begin
            if (!pix_valid) begin
                w_ready      = 1'b1;
                w_stream_rgb = UFLOW_RGB;
                w_uf_set     = 1'b1;
                w_state_nxt  = ST_WAIT_SOF;
            end else if (pix_sof && !w_origin) begin
                w_stream_rgb = UFLOW_RGB;
                w_uf_set     = 1'b1;
                w_state_nxt  = ST_WAIT_SOF;
            end else begin
                w_ready      = 1'b1;
                w_stream_rgb = pix_data;
            end
        end
        if (pixel_rst) begin
            w_ready = 1'b0;
        end
    end

    always_comb begin
        w_pix = BLACK;
        if (w_active) begin
            case (r_mode_q)
                MODE_GRID:   w_pix = w_grid_line ? WHITE : BLACK;
                MODE_BARS:   w_pix = BAR_LUT[bar_index(w_cx)];
                MODE_STREAM: w_pix = w_stream_rgb;
                MODE_SOLID:  w_pix = solid_rgb;
                default:     w_pix = BLACK;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_mode_q <= mode_t'(mode);
            r_state  <= ST_WAIT_SOF;
        end else begin
            if (w_sof_pos) begin
                r_mode_q <= mode_t'(mode);
            end
            r_state <= w_state_nxt;
        end
    end

    // Output stage: everything is one cycle behind the counters and mutually aligned.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_hs          <= !HS_POL;
            r_vs          <= !VS_POL;
            r_blank       <= 1'b0;
            r_rgb         <= BLACK;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_hs          <= w_hs_act ? HS_POL : !HS_POL;
            r_vs          <= w_vs_act ? VS_POL : !VS_POL;
            r_blank       <= w_active;
            r_rgb         <= w_pix;
            r_frame_start <= w_sof_pos;
            if (w_active) begin
                r_x <= w_cx;
                r_y <= w_cy;
            end
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign pix_ready   = w_ready;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign rgb         = r_rgb;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule
